dac_spi_serializer: RTL and testbench
=====================================

# dac_spi_serializer

Downstream stage of the sine generator: takes each 12-bit interpolated sample and ships it to an external 12-bit SPI DAC (MCP4921-style, SPI mode 0). Each 16-bit frame is the 4-bit config nibble followed by the sample, MSB first, then an active-low LDAC pulse latches the DAC output. A ready/valid handshake on the sample side sets the output update rate; samples offered while a frame is in flight are not taken.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per SCK half-period; legal range 1..255.
- CFG_BITS, 4'b0011: frame bits [15:12] (A/B=0, BUF=0, GA=1 for 1x gain, SHDN=1 for active).

Ports (one clock; reset is asynchronous and active-high):
- Clk  input  1  system clock, all flops rising-edge.
- Rst  input  1  asynchronous, active-high reset.
- Sample  input  12  unsigned sample from the interpolator.
- SampleValid  input  1  Sample is valid this cycle.
- Ready  output  1  high only in IDLE; a sample is accepted on a rising edge where SampleValid && Ready.
- Busy  output  1  inverse of Ready.
- Sck  output  1  SPI clock, idles low.
- Mosi  output  1  SPI data, MSB first.
- CsN  output  1  active-low chip select.
- LdacN  output  1  active-low DAC latch strobe.

## Operation
- Reset values: state IDLE, Ready=1, Busy=0, Sck=0, Mosi=0, CsN=1, LdacN=1, shift register 0, counters 0. Reset is asynchronous, so all outputs take these values immediately, mid-frame included. The partial frame is abandoned and never resumed.
- States and transitions:
  - IDLE → SETUP on accept. The shift register loads {CFG_BITS, Sample}.
  - SETUP: CsN=0, Sck=0, Mosi=bit15. Lasts CLK_DIV cycles, then → SHIFT.
  - SHIFT: 16 bits. Each bit is CLK_DIV cycles with Sck=0, then CLK_DIV cycles with Sck=1. Mosi holds the current bit for the whole bit period and changes only at the start of a low phase. After the high phase of bit 0 → HOLD.
  - HOLD: CsN=0, Sck=0, Mosi=0. Lasts CLK_DIV cycles, then → LATCH.
  - LATCH: CsN=1, LdacN=0. Lasts CLK_DIV cycles, then → IDLE.
- Half-period counter: counts CLK_DIV-1 down to 0. Bit counter: 4 bits, counting 15 down to 0.
- Sample and SampleValid are ignored outside IDLE. Nothing is queued or dropped-flagged.
- Sample is captured only in the accept cycle; later changes do not affect the frame in flight.

## Timing
- Accept edge is N; then:
  - CsN falls at N.
  - First Sck rise at N + 2·CLK_DIV.
  - Last Sck fall (start of HOLD) at N + 33·CLK_DIV.
  - CsN rises at N + 34·CLK_DIV.
  - LdacN low for [N + 34·CLK_DIV, N + 35·CLK_DIV).
  - Ready returns at N + 35·CLK_DIV.
- Frame period is 35·CLK_DIV cycles: 140 at the default, 35 at CLK_DIV=1.
- Back-to-back: SampleValid held high is accepted in the first IDLE cycle, giving a period of 35·CLK_DIV + 1. CsN stays high for at least CLK_DIV + 1 cycles between frames.
- All outputs are registered; no combinational path from Sample or SampleValid to any SPI pin. Ready/Busy decode directly from the state register.
- DAC samples Mosi on the Sck rise, with ≥ CLK_DIV cycles of setup and hold.

## Structure
- Shared package holds:
  - state enum {IDLE, SETUP, SHIFT, HOLD, LATCH};
  - FRAME_W=16 and SAMPLE_W=12;
  - the default CFG nibble constant.
- One sub-module, sck_tick_gen: the half-period down-counter. Restart input, terminal-count pulse output, parameterized by CLK_DIV.
- The FSM, shift register and bit counter live in the top module.

## Test plan
- Reset, then Sample=12'hABC with one-cycle SampleValid, CLK_DIV=4 → Mosi captured on Sck rises is 16'h3ABC. Exactly 16 Sck rises. LdacN low 4 cycles starting 136 cycles after accept. Ready back at +140.
- SampleValid held high with Sample stepping 0, 1, 2 → three frames carrying 16'h3000, 16'h3001, 16'h3002, each 141 cycles apart. Sample changes mid-frame do not alter the frame in flight.
- Sample=12'hFFF, then 12'h000, at CLK_DIV=1 → frames 16'h3FFF and 16'h3000. Sck high exactly 1 cycle per bit. Period 35 cycles.
- Rst asserted during bit 7 → CsN=1, Sck=0, Mosi=0, LdacN=1, Ready=1 immediately, with no LdacN pulse. The next accepted sample produces a full, correct 16-bit frame.
- SampleValid pulsed during SHIFT and during LATCH → no acceptance, no change to the frame, no second frame afterwards.

Source files
------------

// File: rtl/dac_spi_serializer_pkg.sv
// Shared types and constants for the DAC SPI serializer.
//   state_e     : frame sequencer states
//   FRAME_W     : bits per SPI frame (config nibble + sample)
//   SAMPLE_W    : sample width from the interpolator
//   CFG_DEFAULT : config nibble {A/B=0, BUF=0, GA=1 (1x), SHDN=1 (active)}
package dac_spi_serializer_pkg;

    localparam int FRAME_W  = 16;
    localparam int SAMPLE_W = 12;

    localparam logic [3:0] CFG_DEFAULT = 4'b0011;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        LATCH
    } state_e;

endpackage

// File: rtl/dac_spi_serializer_if.sv
// Sample handshake plus SPI pin bundle for the DAC serializer.
//   slave  : the serializer (takes Sample/SampleValid, drives everything else)
//   master : the sample source / board side
interface dac_spi_serializer_if;
    import dac_spi_serializer_pkg::*;

    logic [SAMPLE_W-1:0] Sample;
    logic                SampleValid;
    logic                Ready;
    logic                Busy;
    logic                Sck;
    logic                Mosi;
    logic                CsN;
    logic                LdacN;

    modport master (
        output Sample, SampleValid,
        input  Ready, Busy, Sck, Mosi, CsN, LdacN
    );

    modport slave (
        input  Sample, SampleValid,
        output Ready, Busy, Sck, Mosi, CsN, LdacN
    );

endinterface

// File: rtl/dac_spi_serializer_sck_tick_gen.sv
// Half-period timer for the SPI clock.
//   clk, rst : system clock, async active-high reset
//   restart  : reload the counter to CLK_DIV-1 (aligns phases to a frame start)
//   tick     : high in the last cycle of each CLK_DIV-cycle half-period
// Free-running between restarts: reloads itself on terminal count.
module sck_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart || cnt_q == 8'd0) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == 8'd0);

endmodule

// File: rtl/dac_spi_serializer.sv
// Serializes 12-bit samples into 16-bit MCP4921-style SPI frames (mode 0),
// followed by an LDAC strobe.
//   Clk, Rst : system clock, async active-high reset
//   bus      : slave side of dac_spi_serializer_if
//              Sample/SampleValid in, Ready/Busy out, Sck/Mosi/CsN/LdacN out
//
// state | meaning
// IDLE  | Ready high, waiting for SampleValid
// SETUP | CsN low, Mosi = bit 15, one half-period before first Sck rise
// SHIFT | 16 bits, each a low then a high half-period of Sck
// HOLD  | CsN still low after last Sck fall, one half-period
// LATCH | CsN high, LdacN low for one half-period
module dac_spi_serializer
    import dac_spi_serializer_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter logic [3:0]  CFG_BITS = CFG_DEFAULT
) (
    input logic                 Clk,
    input logic                 Rst,
    dac_spi_serializer_if.slave bus
);

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 sck_q, sck_d;
    logic                 csn_q, csn_d;
    logic                 ldacn_q, ldacn_d;

    logic accept;
    logic tick;

    assign accept = (state_q == IDLE) && bus.SampleValid;

    sck_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (Clk),
        .rst     (Rst),
        .restart (accept),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        sck_d     = sck_q;
        csn_d     = csn_q;
        ldacn_d   = ldacn_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SETUP;
                    shift_d   = {CFG_BITS, bus.Sample};
                    bit_cnt_d = 4'd15;
                    sck_d     = 1'b0;
                    csn_d     = 1'b0;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        // Shifting on every falling edge, including the last,
                        // leaves the register all-zero, so Mosi (= MSB) drops
                        // to 0 for HOLD without a separate data flop.
                        sck_d   = 1'b0;
                        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                        if (bit_cnt_q == 4'd0) begin
                            state_d = HOLD;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 4'd1;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = LATCH;
                    csn_d   = 1'b1;
                    ldacn_d = 1'b0;
                end
            end
            LATCH: begin
                if (tick) begin
                    state_d = IDLE;
                    ldacn_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                csn_d   = 1'b1;
                ldacn_d = 1'b1;
                sck_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= 4'd0;
            sck_q     <= 1'b0;
            csn_q     <= 1'b1;
            ldacn_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            sck_q     <= sck_d;
            csn_q     <= csn_d;
            ldacn_q   <= ldacn_d;
        end
    end

    assign bus.Ready = (state_q == IDLE);
    assign bus.Busy  = (state_q != IDLE);
    assign bus.Sck   = sck_q;
    assign bus.Mosi  = shift_q[FRAME_W-1];
    assign bus.CsN   = csn_q;
    assign bus.LdacN = ldacn_q;

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Bench for dac_spi_serializer: one instance at CLK_DIV=4, one at CLK_DIV=1.
// The reference describes a frame purely by its offset from the accept edge.
module tb_dac_spi_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dac_spi_serializer_if if0 ();
    dac_spi_serializer_if if1 ();

    logic        vld [2];
    logic [11:0] smp [2];

    assign if0.SampleValid = vld[0];
    assign if0.Sample      = smp[0];
    assign if1.SampleValid = vld[1];
    assign if1.Sample      = smp[1];

    dac_spi_serializer #(.CLK_DIV(4)) dut0 (.Clk(clk), .Rst(rst), .bus(if0.slave));
    dac_spi_serializer #(.CLK_DIV(1)) dut1 (.Clk(clk), .Rst(rst), .bus(if1.slave));

    int n_total = 0;
    int n_pass  = 0;

    // ---------------- reference model ----------------
    int          cyc = 0;
    int          cd [2] = '{4, 1};
    bit          busy_m [2] = '{1'b0, 1'b0};
    int          acc_n [2] = '{0, 0};
    logic [15:0] acc_w [2];
    int          aq [2][$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                busy_m[k] = 1'b0;
            end else begin
                if (busy_m[k] && (cyc - acc_n[k] > 35 * cd[k])) busy_m[k] = 1'b0;
                if (!busy_m[k] && vld[k]) begin
                    busy_m[k] = 1'b1;
                    acc_n[k]  = cyc;
                    acc_w[k]  = {4'b0011, smp[k]};
                    aq[k].push_back(cyc);
                end
            end
        end
    end

    // Expected pins d cycles after the accept edge (d < 0: no frame).
    task automatic expect_pins(input int d, input int c, input logic [15:0] w,
                               output logic rdy, output logic sck, output logic mosi,
                               output logic csn, output logic ldn);
        rdy = 1'b1; sck = 1'b0; mosi = 1'b0; csn = 1'b1; ldn = 1'b1;
        if (d >= 0 && d < 35 * c) begin
            rdy = 1'b0;
            if (d < c) begin
                csn = 1'b0; mosi = w[15];
            end else if (d < 33 * c) begin
                int r, j;
                r = d - c;
                j = r / (2 * c);
                csn = 1'b0;
                sck = ((r % (2 * c)) >= c);
                mosi = w[15 - j];
            end else if (d < 34 * c) begin
                csn = 1'b0;
            end else begin
                ldn = 1'b0;
            end
        end
    endtask

    // ---------------- pending literal checks ----------------
    string       pn [$];
    logic [31:0] pa [$];
    logic [31:0] pe [$];

    task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
        pn.push_back(n); pa.push_back(a); pe.push_back(e);
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask

    // ---------------- monitor + per-cycle compare ----------------
    logic [15:0] fq [2][$];
    int          rq [2][$];
    logic [15:0] cap [2];
    int          rises [2];
    logic        p_sck [2], p_csn [2], p_ldn [2], p_rdy [2];
    int          ldn_fall [2] = '{0, 0};
    int          ldn_len [2] = '{0, 0};
    int          ldn_falls [2] = '{0, 0};
    int          rdy_rise [2] = '{0, 0};

    always @(negedge clk) begin
        while (pn.size() > 0) chk(pn.pop_front(), pa.pop_front(), pe.pop_front());
        for (int k = 0; k < 2; k++) begin
            logic a_rdy, a_bsy, a_sck, a_mosi, a_csn, a_ldn;
            logic e_rdy, e_sck, e_mosi, e_csn, e_ldn;
            if (k == 0) begin
                a_rdy = if0.Ready; a_bsy = if0.Busy; a_sck = if0.Sck;
                a_mosi = if0.Mosi; a_csn = if0.CsN; a_ldn = if0.LdacN;
            end else begin
                a_rdy = if1.Ready; a_bsy = if1.Busy; a_sck = if1.Sck;
                a_mosi = if1.Mosi; a_csn = if1.CsN; a_ldn = if1.LdacN;
            end
            expect_pins(busy_m[k] ? cyc - acc_n[k] : -1, cd[k], acc_w[k],
                        e_rdy, e_sck, e_mosi, e_csn, e_ldn);
            chk($sformatf("u%0d.Ready@%0d", k, cyc), 32'(a_rdy), 32'(e_rdy));
            chk($sformatf("u%0d.Busy@%0d", k, cyc), 32'(a_bsy), 32'(!e_rdy));
            chk($sformatf("u%0d.Sck@%0d", k, cyc), 32'(a_sck), 32'(e_sck));
            chk($sformatf("u%0d.Mosi@%0d", k, cyc), 32'(a_mosi), 32'(e_mosi));
            chk($sformatf("u%0d.CsN@%0d", k, cyc), 32'(a_csn), 32'(e_csn));
            chk($sformatf("u%0d.LdacN@%0d", k, cyc), 32'(a_ldn), 32'(e_ldn));

            if (rst) begin
                cap[k] = 16'h0; rises[k] = 0;
                p_sck[k] = 1'b0; p_csn[k] = 1'b1; p_ldn[k] = 1'b1; p_rdy[k] = 1'b1;
            end else begin
                if (a_sck && !p_sck[k]) begin
                    cap[k] = {cap[k][14:0], a_mosi};
                    rises[k]++;
                end
                if (a_csn && !p_csn[k]) begin
                    fq[k].push_back(cap[k]); rq[k].push_back(rises[k]);
                    cap[k] = 16'h0; rises[k] = 0;
                end
                if (!a_ldn && p_ldn[k]) begin ldn_fall[k] = cyc; ldn_falls[k]++; end
                if (a_ldn && !p_ldn[k]) ldn_len[k] = cyc - ldn_fall[k];
                if (a_rdy && !p_rdy[k]) rdy_rise[k] = cyc;
                p_sck[k] = a_sck; p_csn[k] = a_csn; p_ldn[k] = a_ldn; p_rdy[k] = a_rdy;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int k, input logic [11:0] s);
        smp[k] = s; vld[k] = 1'b1;
        wait_cycles(1);
        vld[k] = 1'b0;
    endtask

    task automatic wait_frames(input int k, input int target, input int budget);
        int i = 0;
        while (fq[k].size() < target && i < budget) begin
            wait_cycles(1);
            i++;
        end
        lit($sformatf("frames_u%0d", k), 32'(fq[k].size()), 32'(target));
    endtask

    task automatic wait_acc(input int k, input int target, input int budget);
        int i = 0;
        while (aq[k].size() < target && i < budget) begin
            wait_cycles(1);
            i++;
        end
        lit($sformatf("accepts_u%0d", k), 32'(aq[k].size()), 32'(target));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fb, nb, lb;
        vld[0] = 1'b0; vld[1] = 1'b0; smp[0] = 12'h0; smp[1] = 12'h0;
        repeat (3) @(posedge clk);
        #1;
        lit("rst_u0_ready", 32'(if0.Ready), 32'd1);
        lit("rst_u0_busy",  32'(if0.Busy),  32'd0);
        lit("rst_u0_sck",   32'(if0.Sck),   32'd0);
        lit("rst_u0_mosi",  32'(if0.Mosi),  32'd0);
        lit("rst_u0_csn",   32'(if0.CsN),   32'd1);
        lit("rst_u0_ldacn", 32'(if0.LdacN), 32'd1);
        lit("rst_u1_ready", 32'(if1.Ready), 32'd1);
        lit("rst_u1_csn",   32'(if1.CsN),   32'd1);
        rst = 1'b0;
        wait_cycles(3);

        // single frame, CLK_DIV=4
        fb = fq[0].size();
        pulse(0, 12'hABC);
        smp[0] = 12'h000;
        wait_frames(0, fb + 1, 400);
        wait_cycles(10);
        lit("t1_frame", 32'(fq[0][fb]), 32'h3ABC);
        lit("t1_rises", 32'(rq[0][fb]), 32'd16);
        lit("t1_ldac_start", 32'(ldn_fall[0] - aq[0][$]), 32'd136);
        lit("t1_ldac_len", 32'(ldn_len[0]), 32'd4);
        lit("t1_ready_back", 32'(rdy_rise[0] - aq[0][$]), 32'd140);

        // back-to-back with SampleValid held
        fb = fq[0].size(); nb = aq[0].size();
        smp[0] = 12'h000; vld[0] = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            wait_acc(0, nb + s, 400);
            if (s < 3) smp[0] = 12'(s);
            else vld[0] = 1'b0;
        end
        wait_frames(0, fb + 3, 500);
        wait_cycles(200);
        lit("t2_frame0", 32'(fq[0][fb]),     32'h3000);
        lit("t2_frame1", 32'(fq[0][fb + 1]), 32'h3001);
        lit("t2_frame2", 32'(fq[0][fb + 2]), 32'h3002);
        lit("t2_period01", 32'(aq[0][nb + 1] - aq[0][nb]), 32'd141);
        lit("t2_period12", 32'(aq[0][nb + 2] - aq[0][nb + 1]), 32'd141);
        lit("t2_no_extra", 32'(aq[0].size()), 32'(nb + 3));

        // extremes at CLK_DIV=1
        fb = fq[1].size();
        pulse(1, 12'hFFF);
        wait_frames(1, fb + 1, 100);
        wait_cycles(5);
        lit("t3_ready_back", 32'(rdy_rise[1] - aq[1][$]), 32'd35);
        pulse(1, 12'h000);
        wait_frames(1, fb + 2, 100);
        wait_cycles(5);
        lit("t3_frame_fff", 32'(fq[1][fb]),     32'h3FFF);
        lit("t3_frame_000", 32'(fq[1][fb + 1]), 32'h3000);
        lit("t3_rises", 32'(rq[1][fb + 1]), 32'd16);

        // reset during bit 7
        fb = fq[0].size(); lb = ldn_falls[0];
        pulse(0, 12'h123);
        wait_cycles(69);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        lit("t4_csn",   32'(if0.CsN),   32'd1);
        lit("t4_sck",   32'(if0.Sck),   32'd0);
        lit("t4_mosi",  32'(if0.Mosi),  32'd0);
        lit("t4_ldacn", 32'(if0.LdacN), 32'd1);
        lit("t4_ready", 32'(if0.Ready), 32'd1);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(200);
        lit("t4_no_ldac", 32'(ldn_falls[0]), 32'(lb));
        lit("t4_no_frame", 32'(fq[0].size()), 32'(fb));
        pulse(0, 12'h456);
        wait_frames(0, fb + 1, 400);
        wait_cycles(10);
        lit("t4_next_frame", 32'(fq[0][fb]), 32'h3456);
        lit("t4_next_rises", 32'(rq[0][fb]), 32'd16);

        // SampleValid during SHIFT and LATCH is ignored
        fb = fq[0].size(); nb = aq[0].size();
        pulse(0, 12'h7E1);
        wait_cycles(40);
        pulse(0, 12'hFFF);
        wait_cycles(96);
        pulse(0, 12'h0AA);
        wait_cycles(300);
        lit("t5_accepts", 32'(aq[0].size()), 32'(nb + 1));
        lit("t5_frames", 32'(fq[0].size()), 32'(fb + 1));
        lit("t5_frame", 32'(fq[0][fb]), 32'h37E1);

        // random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < 2; k++) begin
                vld[k] = ($urandom_range(0, 7) == 0);
                smp[k] = 12'($urandom);
            end
            wait_cycles(1);
        end
        vld[0] = 1'b0; vld[1] = 1'b0;
        wait_cycles(300);

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
